// File: rtl/net_pkg.sv
// net_pkg: shared definitions for the Ethernet echo client and the MAC
// packet-buffer interfaces (mac_rx_ifc / mac_tx_ifc).
//   ETH_MAX_BYTES / ETH_HDR_BYTES : frame geometry (FCS excluded)
//   pktbuf_t                      : byte-addressed frame buffer
//   client_state_t                : echo client FSM states
//   result_t                      : probe outcome codes
package net_pkg;

    localparam int ETH_MAX_BYTES = 1518;
    localparam int ETH_HDR_BYTES = 14;

    typedef logic [7:0] pktbuf_t [ETH_MAX_BYTES];

    // ST_CHECK screens the header, ST_COMPARE waits on the payload checker.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_PUSH,
        ST_WAIT,
        ST_CHECK,
        ST_COMPARE,
        ST_DONE
    } client_state_t;

    typedef enum logic [1:0] {
        RES_NONE     = 2'b00,
        RES_PASS     = 2'b01,
        RES_MISMATCH = 2'b10,
        RES_TIMEOUT  = 2'b11
    } result_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/echo_payload_checker.sv
// echo_payload_checker: byte-serial comparator for the echoed payload.
// Payload byte i (frame index 14+i) must equal seq+i (mod 256), where seq is
// the sequence number already advanced for this probe.
//   clk, rst : clock, synchronous active-high reset
//   frame    : local copy of the received frame
//   seq      : sequence number of the probe in flight
//   go       : one-cycle start pulse
//   done     : one-cycle pulse when the verdict is ready
//   match    : verdict, valid with done (1 = every byte equal)
module echo_payload_checker
    import net_pkg::*;
#(
    parameter int PAYLOAD_LEN = 46
) (
    input  logic       clk,
    input  logic       rst,
    input  pktbuf_t    frame,
    input  logic [7:0] seq,
    input  logic       go,
    output logic       done,
    output logic       match
);

    localparam logic [10:0] LAST_IDX = 11'(PAYLOAD_LEN - 1);

    logic        active_q, active_d;
    logic [10:0] idx_q, idx_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic [10:0] byte_addr;
    logic [7:0]  exp_byte;

    assign byte_addr = 11'(ETH_HDR_BYTES) + idx_q;
    assign exp_byte  = seq + idx_q[7:0];

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        match_d  = match_q;
        if (go) begin
            active_d = 1'b1;
            idx_d    = '0;
            match_d  = 1'b0;
        end else if (active_q) begin
            // Stop at the first differing byte.
            if (frame[byte_addr] != exp_byte) begin
                active_d = 1'b0;
                done_d   = 1'b1;
                match_d  = 1'b0;
            end else if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
                done_d   = 1'b1;
                match_d  = 1'b1;
            end else begin
                idx_d = idx_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    assign done  = done_q;
    assign match = match_q;

endmodule

// File: rtl/net_echo_client.sv
// net_echo_client: initiator end of the Ethernet echo protocol.
// A start pulse builds a probe frame (header + seq-derived payload) into the
// TX buffer and rings the TX doorbell; the echoed frame is then screened,
// compared byte-serially and reported as pass / mismatch / timeout.
// Optional build macro NET_ECHO_CLIENT_AUTO_EN: also launch a probe after
// 2^26 idle cycles (counted from the previous DONE or from reset).
//   clk, rst           : clock, synchronous active-high reset
//   start              : single-cycle probe request (ignored while busy)
//   tx_pktbuf          : frame bytes for mac_tx_ifc, held until next build
//   tx_pktbuf_maxaddr  : index of last TX frame byte (FCS excluded)
//   tx_doorbell        : one-cycle transmit request
//   tx_available       : mac_tx_ifc idle
//   rx_pktbuf          : received frame bytes
//   rx_pktbuf_maxaddr  : index of last received byte
//   rx_doorbell        : level, high while rx_pktbuf is valid
//   busy, done, result : probe in flight, verdict pulse, verdict code
//   seq                : sequence number of the last probe
//   pass_count         : saturating pass counter
//   fail_count         : saturating mismatch + timeout counter
module net_echo_client
    import net_pkg::*;
#(
    parameter int          PAYLOAD_LEN    = 46,
    parameter logic [47:0] SRC_MAC        = 48'h02_00_00_00_00_01,
    parameter logic [47:0] DST_MAC        = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output pktbuf_t     tx_pktbuf,
    output logic [10:0] tx_pktbuf_maxaddr,
    output logic        tx_doorbell,
    input  logic        tx_available,
    input  pktbuf_t     rx_pktbuf,
    input  logic [10:0] rx_pktbuf_maxaddr,
    input  logic        rx_doorbell,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [7:0]  seq,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count
);

    localparam logic [10:0]  LAST_IDX = 11'(ETH_HDR_BYTES - 1 + PAYLOAD_LEN);
    localparam logic [31:0]  TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

    client_state_t state_q, state_d;
    pktbuf_t       tx_buf_q, tx_buf_d;
    pktbuf_t       rx_buf_q, rx_buf_d;
    logic [10:0]   maxaddr_q, maxaddr_d;
    logic [10:0]   rx_max_q, rx_max_d;
    logic          doorbell_q, doorbell_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    result_t       result_q, result_d;
    logic [7:0]    seq_q, seq_d;
    logic [15:0]   pass_q, pass_d;
    logic [15:0]   fail_q, fail_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          rx_prev_q;

    logic          auto_fire;
    logic          chk_go, chk_done, chk_match;
    logic          verdict_vld;
    result_t       verdict;
    logic [47:0]   rx_dst, rx_src;
    logic [15:0]   rx_type;

`ifdef NET_ECHO_CLIENT_AUTO_EN
    // Counts idle cycles; cleared whenever a probe is in progress.
    logic [25:0] gap_q, gap_d;

    assign gap_d     = (state_q == ST_IDLE) ? gap_q + 26'd1 : '0;
    assign auto_fire = (state_q == ST_IDLE) && (gap_q == '1);

    always_ff @(posedge clk) begin
        if (rst) gap_q <= '0;
        else     gap_q <= gap_d;
    end
`else
    assign auto_fire = 1'b0;
`endif

    echo_payload_checker #(.PAYLOAD_LEN(PAYLOAD_LEN)) u_checker (
        .clk   (clk),
        .rst   (rst),
        .frame (rx_buf_q),
        .seq   (seq_q),
        .go    (chk_go),
        .done  (chk_done),
        .match (chk_match)
    );

    // Header fields of the captured frame, MSB first on the wire.
    always_comb begin
        rx_dst = '0;
        rx_src = '0;
        for (int i = 0; i < 6; i++) begin
            rx_dst[47-8*i -: 8] = rx_buf_q[i];
            rx_src[47-8*i -: 8] = rx_buf_q[6+i];
        end
        rx_type = {rx_buf_q[12], rx_buf_q[13]};
    end

    always_comb begin
        state_d     = state_q;
        tx_buf_d    = tx_buf_q;
        rx_buf_d    = rx_buf_q;
        maxaddr_d   = maxaddr_q;
        rx_max_d    = rx_max_q;
        doorbell_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        seq_d       = seq_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        tmo_d       = tmo_q;
        chk_go      = 1'b0;
        verdict_vld = 1'b0;
        verdict     = RES_NONE;

        // Timeout counter runs (and saturates) across WAIT and both check
        // phases, so a timeout hit during a check fires on return to WAIT.
        if ((state_q == ST_WAIT || state_q == ST_CHECK || state_q == ST_COMPARE)
            && tmo_q != TMO_LAST)
            tmo_d = tmo_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_fire) begin
                    state_d = ST_BUILD;
                    busy_d  = 1'b1;
                end
            end
            ST_BUILD: begin
                for (int i = 0; i < ETH_HDR_BYTES; i++)
                    tx_buf_d[i] = HDR[111-8*i -: 8];
                for (int i = 0; i < PAYLOAD_LEN; i++)
                    tx_buf_d[ETH_HDR_BYTES+i] = seq_q + 8'd1 + 8'(i);
                maxaddr_d = LAST_IDX;
                seq_d     = seq_q + 8'd1;
                state_d   = ST_PUSH;
            end
            ST_PUSH: begin
                if (tx_available) begin
                    doorbell_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmo_q == TMO_LAST) begin
                    verdict_vld = 1'b1;
                    verdict     = RES_TIMEOUT;
                end else if (rx_doorbell && !rx_prev_q) begin
                    rx_buf_d = rx_pktbuf;
                    rx_max_d = rx_pktbuf_maxaddr;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_dst != SRC_MAC || rx_type != ETHERTYPE) begin
                    // Not addressed to us: keep waiting, timer untouched.
                    state_d = ST_WAIT;
                end else if (rx_src != DST_MAC || rx_max_q < LAST_IDX) begin
                    verdict_vld = 1'b1;
                    verdict     = RES_MISMATCH;
                end else begin
                    chk_go  = 1'b1;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (chk_done) begin
                    verdict_vld = 1'b1;
                    verdict     = chk_match ? RES_PASS : RES_MISMATCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so the verdict is applied on entry to DONE
        // and is visible together with the done pulse.
        if (verdict_vld) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            result_d = verdict;
            if (verdict == RES_PASS) pass_d = sat_inc16(pass_q);
            else                     fail_d = sat_inc16(fail_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_buf_q   <= '{default: 8'h00};
            maxaddr_q  <= '0;
            doorbell_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= RES_NONE;
            seq_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            tmo_q      <= '0;
            rx_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_buf_q   <= tx_buf_d;
            maxaddr_q  <= maxaddr_d;
            doorbell_q <= doorbell_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            seq_q      <= seq_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            rx_prev_q  <= rx_doorbell;
        end
    end

    // Captured RX frame is only read after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        rx_buf_q <= rx_buf_d;
        rx_max_q <= rx_max_d;
    end

    assign tx_pktbuf         = tx_buf_q;
    assign tx_pktbuf_maxaddr = maxaddr_q;
    assign tx_doorbell       = doorbell_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign result            = result_q;
    assign seq               = seq_q;
    assign pass_count        = pass_q;
    assign fail_count        = fail_q;

endmodule
